// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between the CPU and the DMA engine.
// Each grant runs a fixed-latency access, then a single done cycle.
module mem_port_arbiter #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic              io_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_re,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic last_io_q, last_io_d;
  logic we_q, we_d;

  logic cpu_gnt_d, io_gnt_d;
  logic cpu_done_d, io_done_d;
  logic ram_re_d, ram_we_d, busy_d;
  logic [DATA_W-1:0] rdata_d, ram_wdata_d;
  logic [ADDR_W-1:0] ram_addr_d;

  // IO wins only when alone or when the CPU owned the last access
  logic pick_io;
  assign pick_io = io_req & (~cpu_req | ~last_io_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_io_d   = last_io_q;
    we_d        = we_q;
    cpu_gnt_d   = cpu_gnt;
    io_gnt_d    = io_gnt;
    cpu_done_d  = 1'b0;
    io_done_d   = 1'b0;
    ram_re_d    = ram_re;
    ram_we_d    = ram_we;
    busy_d      = busy;
    rdata_d     = rdata;
    ram_addr_d  = ram_addr;
    ram_wdata_d = ram_wdata;
    unique case (state_q)
      IDLE: begin
        if (cpu_req || io_req) begin
          state_d     = ACCESS;
          cnt_d       = LAT_M1;
          last_io_d   = pick_io;
          we_d        = pick_io ? io_we : cpu_we;
          ram_addr_d  = pick_io ? io_addr : cpu_addr;
          ram_wdata_d = pick_io ? io_wdata : cpu_wdata;
          cpu_gnt_d   = ~pick_io;
          io_gnt_d    = pick_io;
          ram_re_d    = ~we_d;
          ram_we_d    = we_d;
          busy_d      = 1'b1;
        end
      end
      ACCESS: begin
        ram_we_d = 1'b0;
        if (cnt_q == 4'd0) begin
          state_d    = DONE;
          cpu_gnt_d  = 1'b0;
          io_gnt_d   = 1'b0;
          ram_re_d   = 1'b0;
          cpu_done_d = ~last_io_q;
          io_done_d  = last_io_q;
          if (!we_q) rdata_d = ram_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      last_io_q <= 1'b1;
      we_q      <= 1'b0;
      cpu_gnt   <= 1'b0;
      io_gnt    <= 1'b0;
      cpu_done  <= 1'b0;
      io_done   <= 1'b0;
      ram_re    <= 1'b0;
      ram_we    <= 1'b0;
      busy      <= 1'b0;
      rdata     <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_io_q <= last_io_d;
      we_q      <= we_d;
      cpu_gnt   <= cpu_gnt_d;
      io_gnt    <= io_gnt_d;
      cpu_done  <= cpu_done_d;
      io_done   <= io_done_d;
      ram_re    <= ram_re_d;
      ram_we    <= ram_we_d;
      busy      <= busy_d;
      rdata     <= rdata_d;
      ram_addr  <= ram_addr_d;
      ram_wdata <= ram_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle tables for two latency builds plus
// a scoreboard that tracks every access through the RAM strobes.
module tb_mem_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic a_cpu_req = 0, a_cpu_we = 0, a_io_req = 0, a_io_we = 0;
  logic [AW-1:0] a_cpu_addr = '0, a_io_addr = '0;
  logic [DW-1:0] a_cpu_wdata = '0, a_io_wdata = '0;
  logic a_cpu_gnt, a_cpu_done, a_io_gnt, a_io_done;
  logic a_ram_re, a_ram_we, a_busy;
  logic [DW-1:0] a_rdata, a_ram_wdata, a_ram_rdata;
  logic [AW-1:0] a_ram_addr;

  logic b_cpu_req = 0, b_cpu_we = 0, b_io_req = 0, b_io_we = 0;
  logic [AW-1:0] b_cpu_addr = '0, b_io_addr = '0;
  logic [DW-1:0] b_cpu_wdata = '0, b_io_wdata = '0;
  logic b_cpu_gnt, b_cpu_done, b_io_gnt, b_io_done;
  logic b_ram_re, b_ram_we, b_busy;
  logic [DW-1:0] b_rdata, b_ram_wdata, b_ram_rdata;
  logic [AW-1:0] b_ram_addr;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(2)) dut_a (
    .clock(clock), .reset(reset),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we),
    .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_gnt(a_cpu_gnt), .cpu_done(a_cpu_done),
    .io_req(a_io_req), .io_we(a_io_we),
    .io_addr(a_io_addr), .io_wdata(a_io_wdata),
    .io_gnt(a_io_gnt), .io_done(a_io_done),
    .rdata(a_rdata), .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata),
    .ram_re(a_ram_re), .ram_we(a_ram_we), .ram_rdata(a_ram_rdata),
    .busy(a_busy)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1)) dut_b (
    .clock(clock), .reset(reset),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we),
    .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_gnt(b_cpu_gnt), .cpu_done(b_cpu_done),
    .io_req(b_io_req), .io_we(b_io_we),
    .io_addr(b_io_addr), .io_wdata(b_io_wdata),
    .io_gnt(b_io_gnt), .io_done(b_io_done),
    .rdata(b_rdata), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
    .ram_re(b_ram_re), .ram_we(b_ram_we), .ram_rdata(b_ram_rdata),
    .busy(b_busy)
  );

  logic [6:0] a_o, b_o;
  assign a_o = {a_cpu_gnt, a_io_gnt, a_ram_re, a_ram_we, a_cpu_done, a_io_done, a_busy};
  assign b_o = {b_cpu_gnt, b_io_gnt, b_ram_re, b_ram_we, b_cpu_done, b_io_done, b_busy};

  logic [DW-1:0] mem [0:511];
  logic [DW-1:0] shadow [0:511];
  assign a_ram_rdata = mem[a_ram_addr];
  assign b_ram_rdata = mem[b_ram_addr];

  always @(posedge clock) begin
    if (a_ram_we) mem[a_ram_addr] = a_ram_wdata;
    if (b_ram_we) mem[b_ram_addr] = b_ram_wdata;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic io;
    logic we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rd;
  } txn_t;

  txn_t sb[$];
  logic [DW-1:0] last_rd = '0;

  task automatic push(input logic io, input logic we,
                      input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    txn_t t;
    t.io = io; t.we = we; t.addr = ad; t.wdata = wd;
    if (we) begin
      shadow[ad] = wd;
      t.rd = last_rd;
    end else begin
      t.rd = shadow[ad];
      last_rd = t.rd;
    end
    sb.push_back(t);
  endtask

  // Scoreboard side: strobes and done pulses of the latency-2 build
  always @(negedge clock) begin : mon
    txn_t t;
    check("A gnt overlap", 64'(a_cpu_gnt & a_io_gnt), 64'd0);
    check("A done overlap", 64'(a_cpu_done & a_io_done), 64'd0);
    if (a_ram_re || a_ram_we) begin
      check("A sb depth at strobe", 64'(sb.size()), 64'd1);
      if (sb.size() > 0) begin
        t = sb[0];
        check("A ram_addr", 64'(a_ram_addr), 64'(t.addr));
        check("A strobe type", 64'({a_ram_we, a_ram_re}), t.we ? 64'd2 : 64'd1);
        if (a_ram_we) check("A ram_wdata", 64'(a_ram_wdata), 64'(t.wdata));
      end
    end
    if (a_cpu_done || a_io_done) begin
      check("A sb depth at done", 64'(sb.size()), 64'd1);
      if (sb.size() > 0) begin
        t = sb.pop_front();
        check("A done owner", 64'({a_cpu_done, a_io_done}), t.io ? 64'd1 : 64'd2);
        check("A done rdata", 64'(a_rdata), 64'(t.rd));
      end
    end
  end

  typedef struct {
    logic cr, cw;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic ir, iw;
    logic [AW-1:0] ia;
    logic [DW-1:0] id;
    logic [6:0] exp;
    int s;
    logic crd;
    logic [DW-1:0] rd;
  } row_t;

  row_t rows[$];

  function automatic void r(input logic cr, input logic cw,
                            input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                            input logic ir, input logic iw,
                            input logic [AW-1:0] ia, input logic [DW-1:0] id,
                            input logic [6:0] exp, input int s,
                            input logic crd, input logic [DW-1:0] rd);
    row_t x;
    x.cr = cr; x.cw = cw; x.ca = ca; x.cd = cd;
    x.ir = ir; x.iw = iw; x.ia = ia; x.id = id;
    x.exp = exp; x.s = s; x.crd = crd; x.rd = rd;
    rows.push_back(x);
  endfunction

  // Row inputs are sampled by the edge ending that row; outputs checked mid-row
  task automatic apply(input bit on_b, input string tag);
    foreach (rows[i]) begin
      @(posedge clock);
      #1;
      if (!on_b) begin
        a_cpu_req = rows[i].cr; a_cpu_we = rows[i].cw;
        a_cpu_addr = rows[i].ca; a_cpu_wdata = rows[i].cd;
        a_io_req = rows[i].ir; a_io_we = rows[i].iw;
        a_io_addr = rows[i].ia; a_io_wdata = rows[i].id;
        if (rows[i].s == 1) push(1'b0, rows[i].cw, rows[i].ca, rows[i].cd);
        if (rows[i].s == 2) push(1'b1, rows[i].iw, rows[i].ia, rows[i].id);
      end else begin
        b_cpu_req = rows[i].cr; b_cpu_we = rows[i].cw;
        b_cpu_addr = rows[i].ca; b_cpu_wdata = rows[i].cd;
        b_io_req = rows[i].ir; b_io_we = rows[i].iw;
        b_io_addr = rows[i].ia; b_io_wdata = rows[i].id;
      end
      @(negedge clock);
      check($sformatf("%s row%0d outs", tag, i), 64'(on_b ? b_o : a_o), 64'(rows[i].exp));
      if (rows[i].crd)
        check($sformatf("%s row%0d rdata", tag, i),
              64'(on_b ? b_rdata : a_rdata), 64'(rows[i].rd));
    end
    rows.delete();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    for (int i = 0; i < 512; i++) begin
      mem[i] = 32'hA500_0000 | 32'(i);
      shadow[i] = 32'hA500_0000 | 32'(i);
    end
    mem[9'h010] = 32'hDEADBEEF;
    shadow[9'h010] = 32'hDEADBEEF;

    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("A reset outs", 64'(a_o), 64'd0);
    check("A reset rdata", 64'(a_rdata), 64'd0);
    check("A reset ram_addr", 64'(a_ram_addr), 64'd0);
    check("A reset ram_wdata", 64'(a_ram_wdata), 64'd0);
    check("B reset outs", 64'(b_o), 64'd0);
    check("B reset rdata", 64'(b_rdata), 64'd0);
    @(posedge clock);
    #1 reset = 1'b1;

    // CPU read, IO write, then both held for four alternating accesses
    r(1,0,9'h010,0, 0,0,0,0, 7'b0000000, 1, 1, 0);
    r(1,0,9'h010,0, 0,0,0,0, 7'b1010001, 0, 0, 0);
    r(1,0,9'h010,0, 0,0,0,0, 7'b1010001, 0, 0, 0);
    r(1,0,9'h010,0, 0,0,0,0, 7'b0000101, 0, 1, 32'hDEADBEEF);
    r(0,0,0,0, 0,0,0,0, 7'b0000000, 0, 0, 0);
    r(0,0,0,0, 1,1,9'h1FF,32'h12345678, 7'b0000000, 2, 0, 0);
    r(0,0,0,0, 1,1,9'h1FF,32'h12345678, 7'b0101001, 0, 0, 0);
    r(0,0,0,0, 1,1,9'h1FF,32'h12345678, 7'b0100001, 0, 0, 0);
    r(0,0,0,0, 1,1,9'h1FF,32'h12345678, 7'b0000011, 0, 1, 32'hDEADBEEF);
    r(0,0,0,0, 0,0,0,0, 7'b0000000, 0, 0, 0);
    r(1,0,9'h020,0, 1,1,9'h030,32'hA5A50001, 7'b0000000, 1, 0, 0);
    r(1,0,9'h020,0, 1,1,9'h030,32'hA5A50001, 7'b1010001, 0, 0, 0);
    r(1,0,9'h020,0, 1,1,9'h030,32'hA5A50001, 7'b1010001, 0, 0, 0);
    r(1,0,9'h020,0, 1,1,9'h030,32'hA5A50001, 7'b0000101, 0, 1, 32'hA5000020);
    r(1,0,9'h020,0, 1,1,9'h030,32'hA5A50001, 7'b0000000, 2, 0, 0);
    r(1,0,9'h020,0, 1,1,9'h030,32'hA5A50001, 7'b0101001, 0, 0, 0);
    r(1,0,9'h020,0, 1,1,9'h030,32'hA5A50001, 7'b0100001, 0, 0, 0);
    r(1,0,9'h020,0, 1,1,9'h030,32'hA5A50001, 7'b0000011, 0, 1, 32'hA5000020);
    r(1,0,9'h021,0, 1,1,9'h031,32'hA5A50002, 7'b0000000, 1, 0, 0);
    r(1,0,9'h021,0, 1,1,9'h031,32'hA5A50002, 7'b1010001, 0, 0, 0);
    r(1,0,9'h021,0, 1,1,9'h031,32'hA5A50002, 7'b1010001, 0, 0, 0);
    r(1,0,9'h021,0, 1,1,9'h031,32'hA5A50002, 7'b0000101, 0, 1, 32'hA5000021);
    r(1,0,9'h021,0, 1,1,9'h031,32'hA5A50002, 7'b0000000, 2, 0, 0);
    r(1,0,9'h021,0, 1,1,9'h031,32'hA5A50002, 7'b0101001, 0, 0, 0);
    r(1,0,9'h021,0, 1,1,9'h031,32'hA5A50002, 7'b0100001, 0, 0, 0);
    r(1,0,9'h021,0, 1,1,9'h031,32'hA5A50002, 7'b0000011, 0, 1, 32'hA5000021);
    r(0,0,0,0, 0,0,0,0, 7'b0000000, 0, 0, 0);
    apply(1'b0, "A");

    // Request dropped and address changed mid-access
    r(1,0,9'h040,0, 0,0,0,0, 7'b0000000, 1, 0, 0);
    r(0,0,9'h0AA,0, 0,0,0,0, 7'b1010001, 0, 0, 0);
    r(0,0,9'h0AA,0, 0,0,0,0, 7'b1010001, 0, 0, 0);
    r(0,0,9'h0AA,0, 0,0,0,0, 7'b0000101, 0, 1, 32'hA5000040);
    r(0,0,0,0, 0,0,0,0, 7'b0000000, 0, 0, 0);
    apply(1'b0, "A-drop");

    // Reset taken in the middle of a CPU read
    @(posedge clock);
    #1;
    a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 9'h070;
    push(1'b0, 1'b0, 9'h070, '0);
    @(posedge clock);
    #2;
    check("A gnt before reset", 64'(a_o), 64'b1010001);
    reset = 1'b0;
    #1;
    check("A outs async reset", 64'(a_o), 64'd0);
    check("A rdata async reset", 64'(a_rdata), 64'd0);
    check("A ram_addr async reset", 64'(a_ram_addr), 64'd0);
    sb.delete();
    last_rd = '0;
    a_cpu_req = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;

    r(0,0,0,0, 1,0,9'h080,0, 7'b0000000, 2, 1, 0);
    r(0,0,0,0, 1,0,9'h080,0, 7'b0110001, 0, 0, 0);
    r(0,0,0,0, 1,0,9'h080,0, 7'b0110001, 0, 0, 0);
    r(0,0,0,0, 1,0,9'h080,0, 7'b0000011, 0, 1, 32'hA5000080);
    r(0,0,0,0, 0,0,0,0, 7'b0000000, 0, 0, 0);
    apply(1'b0, "A-post-reset");

    // Latency-1 build: first tie after reset goes to the CPU
    r(1,0,9'h050,0, 1,0,9'h060,0, 7'b0000000, 0, 0, 0);
    r(1,0,9'h050,0, 1,0,9'h060,0, 7'b1010001, 0, 0, 0);
    r(1,0,9'h050,0, 1,0,9'h060,0, 7'b0000101, 0, 1, 32'hA5000050);
    r(0,0,0,0, 1,0,9'h060,0, 7'b0000000, 0, 0, 0);
    r(0,0,0,0, 1,0,9'h060,0, 7'b0110001, 0, 0, 0);
    r(0,0,0,0, 1,0,9'h060,0, 7'b0000011, 0, 1, 32'hA5000060);
    r(0,0,0,0, 0,0,0,0, 7'b0000000, 0, 0, 0);
    apply(1'b1, "B");

    repeat (3) @(negedge clock);
    check("A scoreboard drained", 64'(sb.size()), 64'd0);
    check("A IO write landed", 64'(mem[9'h1FF]), 64'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port main memory between two requesters: the CPU control unit (MAR/MDR fetch and load/store path) and the I/O DMA engine.
- Serializes accesses, applies round-robin priority, and drives the memory strobes for a fixed access latency.
- Returns read data and a one-cycle completion pulse to the granted requester.
- Sits between the requesters and the RAM.

Parameters:
- ADDR_W, 9, memory address width.
- DATA_W, 32, memory data width.
- MEM_LATENCY, 2, cycles the RAM needs per access; legal range 1..15.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_done.
- cpu_we  in  1  1 = write, 0 = read; valid while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU currently owns the memory port.
- cpu_done  out  1  one-cycle completion pulse to the CPU.
- io_req, io_we, io_addr, io_wdata  in  1/1/ADDR_W/DATA_W  same meaning as the CPU inputs, for the DMA engine.
- io_gnt  out  1  DMA engine currently owns the memory port.
- io_done  out  1  one-cycle completion pulse to the DMA engine.
- rdata  out  DATA_W  read data; valid in the done cycle and held until the next read completes.
- ram_addr  out  ADDR_W  memory address.
- ram_wdata  out  DATA_W  memory write data.
- ram_re  out  1  memory read strobe.
- ram_we  out  1  memory write strobe.
- ram_rdata  in  DATA_W  memory read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered.
- Reset (reset = 0, asynchronous) sets every output to 0, rdata to 0, state to IDLE, wait counter to 0, and last_owner to IO.
- A reset taken mid-access aborts the access: no done pulse is issued, and a write may or may not have landed.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: remain in IDLE.
  - Exactly one request: grant that requester.
  - Both requests: grant the requester that is not last_owner, so the CPU wins the first tie after reset.
  - On grant: latch we, addr and wdata into internal registers; set last_owner to the grantee; load the counter with MEM_LATENCY-1; go to ACCESS.
- ACCESS:
  - gnt of the grantee is high for the whole state.
  - ram_addr and ram_wdata come from the latched registers.
  - Read: ram_re is high for all MEM_LATENCY cycles.
  - Write: ram_we is high in the first ACCESS cycle only.
  - The counter decrements each cycle.
  - On the cycle the counter is 0: sample ram_rdata into rdata (reads only; writes leave rdata unchanged), then go to DONE.
- DONE:
  - The grantee's done is high for exactly one cycle.
  - gnt, ram_re and ram_we are low.
  - Next state is IDLE.
- Latency: request sampled at edge k leads to:
  - gnt and strobes high over cycles k+1 .. k+MEM_LATENCY;
  - done in cycle k+MEM_LATENCY+1;
  - the earliest next grant starting at cycle k+MEM_LATENCY+3.
- Throughput is one access per MEM_LATENCY+2 cycles under back-to-back load.
- No fairness starvation: with both requests held continuously, grants strictly alternate CPU, IO, CPU, ...
- Requests arriving during ACCESS or DONE are not sampled until IDLE.
- Request inputs changing or dropping mid-access are ignored: the access completes with the latched values and done still pulses.
- A requester must deassert req in the cycle after done or it is treated as a new request. Keeping req high counts as a new back-to-back request, subject to round-robin.
- cpu_gnt and io_gnt are never high together; cpu_done and io_done are never high together.
- MEM_LATENCY = 1: ACCESS lasts one cycle, ram_re and ram_we are single-cycle, and rdata is sampled in that same cycle.

Test Plan:
- Reset, then CPU read addr 0x010 with ram_rdata 0xDEADBEEF and MEM_LATENCY=2 → cpu_gnt and ram_re high 2 cycles, ram_addr=0x010, cpu_done 1 cycle later, rdata=0xDEADBEEF, io_* stay 0.
- IO write addr 0x1FF, data 0x12345678 → ram_we high exactly 1 cycle with ram_addr=0x1FF and ram_wdata=0x12345678; io_done pulses; rdata unchanged.
- cpu_req and io_req asserted together and held for 4 accesses → grant order CPU, IO, CPU, IO; never both gnt high; each access spans 4 cycles including the done cycle.
- CPU read in progress, cpu_addr changed to 0x0AA and cpu_req dropped after 1 cycle → ram_addr stays at the original address and cpu_done still pulses once.
- reset asserted low during ACCESS → all outputs 0 asynchronously; after release, io_req alone is granted first.
- MEM_LATENCY=1 build, CPU read → gnt and ram_re high 1 cycle, cpu_done in the following cycle, busy high exactly 2 cycles.
